simd_host_link: RTL and testbench

- Host-side initiator for the 4-lane serial SIMD core.
- Takes four parallel operand pairs plus an opcode from a requester. Shifts the operands bit-serially into the core's per-lane SIPO inputs, pulses the core's send strobe, then collects the four bit-serial result streams back into parallel words.
- Sits between the Pico-facing register or command logic and the SIMD core's data_in[7:0] / data[3:0] pins.

---
 rtl/simd_host_link.sv | 143 ++++++++++++++
 tb/tb_simd_host_link.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/simd_host_link.sv
// Host-side initiator for the 4-lane serial SIMD core: shifts operand pairs out
// MSB-first, strobes send, then collects four bit-serial result streams.
module simd_host_link #(
  parameter int BW  = 32,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4*BW-1:0] a_vec,
  input  logic [4*BW-1:0] b_vec,
  input  logic [3:0]      mode_in,
  input  logic            dtype_in,
  output logic            busy,
  output logic            done,
  output logic [4*BW-1:0] result_vec,
  output logic            load,
  output logic [3:0]      mode,
  output logic            dtype,
  output logic [7:0]      data_out,
  output logic            send,
  input  logic [3:0]      data_in
);

  localparam int CW = $clog2(BW) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RECV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     bcnt;
  logic [3:0]        lat_cnt;
  logic [4*BW-1:0]   a_sr;
  logic [4*BW-1:0]   b_sr;
  logic [4*BW-1:0]   r_sr;

  // Per-lane left shift, each lane's LSB filled from the matching bit of f.
  function automatic logic [4*BW-1:0] shl(input logic [4*BW-1:0] v, input logic [3:0] f);
    logic [4*BW-1:0] r;
    for (int unsigned k = 0; k < 4; k++)
      r[k*BW +: BW] = {v[k*BW +: BW-1], f[k]};
    return r;
  endfunction

  function automatic logic [3:0] msb4(input logic [4*BW-1:0] v);
    logic [3:0] r;
    for (int unsigned k = 0; k < 4; k++)
      r[k] = v[k*BW + BW - 1];
    return r;
  endfunction

  // A lane k on even pin 2k, B lane k on odd pin 2k+1.
  function automatic logic [7:0] pins(input logic [3:0] a4, input logic [3:0] b4);
    logic [7:0] r;
    for (int unsigned k = 0; k < 4; k++) begin
      r[2*k]   = a4[k];
      r[2*k+1] = b4[k];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      lat_cnt    <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_vec <= '0;
      load       <= 1'b0;
      mode       <= '0;
      dtype      <= 1'b0;
      data_out   <= '0;
      send       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // First MSBs go straight out on the accepting edge; the shift
            // registers keep the remaining bits already advanced by one.
            a_sr     <= shl(a_vec, '0);
            b_sr     <= shl(b_vec, '0);
            data_out <= pins(msb4(a_vec), msb4(b_vec));
            mode     <= mode_in;
            dtype    <= dtype_in;
            load     <= 1'b1;
            busy     <= 1'b1;
            bcnt     <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (bcnt == CW'(BW - 1)) begin
            load     <= 1'b0;
            data_out <= '0;
            send     <= 1'b1;
            bcnt     <= '0;
            state    <= SEND;
          end else begin
            data_out <= pins(msb4(a_sr), msb4(b_sr));
            a_sr     <= shl(a_sr, '0);
            b_sr     <= shl(b_sr, '0);
            bcnt     <= bcnt + CW'(1);
          end
        end
        SEND: begin
          send    <= 1'b0;
          lat_cnt <= '0;
          bcnt    <= '0;
          state   <= (LAT == 0) ? RECV : WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'(LAT - 1)) begin
            bcnt  <= '0;
            state <= RECV;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RECV: begin
          r_sr <= shl(r_sr, data_in);
          if (bcnt == CW'(BW - 1)) begin
            result_vec <= shl(r_sr, data_in);
            done       <= 1'b1;
            bcnt       <= '0;
            state      <= DONE;
          end else begin
            bcnt <= bcnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_host_link.sv
// Directed bench for simd_host_link: two instances (LAT=1 and LAT=0), each
// looped back through a behavioural SIPO/adder/PISO core model.
module tb_simd_host_link;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   start;
  logic [127:0] a_vec, b_vec;
  logic [3:0]   mode_in;
  logic         dtype_in;

  logic [1:0]   busy, done, load, send, dtype_o;
  logic [3:0]   mode_o [2];
  logic [7:0]   dout   [2];
  logic [127:0] res    [2];
  logic [3:0]   din    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [127:0] last_res [2];

  always #5 clk = ~clk;

  simd_host_link #(.BW(32), .LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a_vec(a_vec), .b_vec(b_vec),
    .mode_in(mode_in), .dtype_in(dtype_in), .busy(busy[0]), .done(done[0]),
    .result_vec(res[0]), .load(load[0]), .mode(mode_o[0]), .dtype(dtype_o[0]),
    .data_out(dout[0]), .send(send[0]), .data_in(din[0]));

  simd_host_link #(.BW(32), .LAT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a_vec(a_vec), .b_vec(b_vec),
    .mode_in(mode_in), .dtype_in(dtype_in), .busy(busy[1]), .done(done[1]),
    .result_vec(res[1]), .load(load[1]), .mode(mode_o[1]), .dtype(dtype_o[1]),
    .data_out(dout[1]), .send(send[1]), .data_in(din[1]));

  // Core model: SIPO per operand, adder on send, PISO held for LAT cycles.
  logic [31:0] sa [2][4];
  logic [31:0] sb [2][4];
  logic [31:0] po [2][4];
  logic [3:0]  dly [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        dly[s] <= '0;
        for (int k = 0; k < 4; k++) begin
          sa[s][k] <= '0;
          sb[s][k] <= '0;
          po[s][k] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (load[s])
          for (int k = 0; k < 4; k++) begin
            sa[s][k] <= {sa[s][k][30:0], dout[s][2*k]};
            sb[s][k] <= {sb[s][k][30:0], dout[s][2*k+1]};
          end
        if (send[s]) begin
          for (int k = 0; k < 4; k++) po[s][k] <= sa[s][k] + sb[s][k];
          dly[s] <= (s == 0) ? 4'd1 : 4'd0;
        end else if (dly[s] != 4'd0) begin
          dly[s] <= dly[s] - 4'd1;
        end else begin
          for (int k = 0; k < 4; k++) po[s][k] <= {po[s][k][30:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    din[0] = '0;
    din[1] = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) din[s][k] = po[s][k][31];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    start = '0;
  endtask

  // One full transaction on instance s; poke adds ignored starts and input churn.
  task automatic txn(input int s, input logic [127:0] a, input logic [127:0] b,
                     input logic [127:0] exp, input logic [3:0] m, input logic d,
                     input bit poke);
    int dc;
    logic [7:0] edo;
    dc = (s == 0) ? 67 : 66;
    a_vec = a; b_vec = b; mode_in = m; dtype_in = d;
    start[s] = 1'b1;
    cyc = 0;
    step;
    while (cyc <= dc) begin
      check("done", done[s], cyc == dc);
      check("busy", busy[s], 1'b1);
      check("load", load[s], cyc <= 32);
      check("send", send[s], cyc == 33);
      check("mode", mode_o[s], m);
      check("dtype", dtype_o[s], d);
      edo = '0;
      if (cyc <= 32)
        for (int k = 0; k < 4; k++) begin
          edo[2*k]   = a[k*32 + 32 - cyc];
          edo[2*k+1] = b[k*32 + 32 - cyc];
        end
      check("data_out", dout[s], edo);
      check("result", res[s], (cyc == dc) ? exp : last_res[s]);
      if (poke && cyc == 5) begin
        mode_in = ~m; dtype_in = ~d;
      end
      if (poke && (cyc == 10 || cyc == dc)) begin
        a_vec = ~a; b_vec = ~b; mode_in = m + 4'd1;
        start[s] = 1'b1;
      end
      step;
    end
    last_res[s] = exp;
    check("idle_busy", busy[s], 1'b0);
    check("idle_done", done[s], 1'b0);
    check("idle_result", res[s], exp);
    check("idle_mode", mode_o[s], m);
  endtask

  localparam logic [127:0] SH_A = 128'h00000000_00000000_00000000_80000001;
  localparam logic [127:0] SH_B = 128'h00000000_00000000_00000000_00000003;
  localparam logic [127:0] SH_R = 128'h00000000_00000000_00000000_80000004;
  localparam logic [127:0] LB_A = 128'h7FFFFFFF_00000064_FFFFFFFF_00000005;
  localparam logic [127:0] LB_B = 128'h00000001_00000017_00000001_00000007;
  localparam logic [127:0] LB_R = 128'h80000000_0000007B_00000000_0000000C;

  initial begin
    rst = 1'b1; start = '0; a_vec = '0; b_vec = '0; mode_in = '0; dtype_in = 1'b0;
    last_res[0] = '0; last_res[1] = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", busy[s], 1'b0);
      check("rst_done", done[s], 1'b0);
      check("rst_load", load[s], 1'b0);
      check("rst_send", send[s], 1'b0);
      check("rst_data_out", dout[s], 8'h00);
      check("rst_result", res[s], '0);
      check("rst_mode", mode_o[s], 4'h0);
      check("rst_dtype", dtype_o[s], 1'b0);
    end
    @(negedge clk) rst = 1'b0;
    step;

    // Shift pattern, then loopback add with ignored starts and mode churn,
    // then a back-to-back start on the first IDLE cycle.
    txn(0, SH_A, SH_B, SH_R, 4'h0, 1'b0, 1'b0);
    txn(0, LB_A, LB_B, LB_R, 4'h0, 1'b1, 1'b1);
    txn(0, SH_A, SH_B, SH_R, 4'h5, 1'b0, 1'b0);

    // Reset during LOAD cycle 15, asserted between clock edges.
    a_vec = LB_A; b_vec = LB_B; mode_in = 4'h9; dtype_in = 1'b1;
    start[0] = 1'b1;
    cyc = 0;
    step;
    while (cyc < 15) step;
    check("pre_rst_load", load[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_load", load[0], 1'b0);
    check("abort_send", send[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_data_out", dout[0], 8'h00);
    check("abort_done", done[0], 1'b0);
    check("abort_result", res[0], '0);
    step;
    @(negedge clk) rst = 1'b0;
    last_res[0] = '0; last_res[1] = '0;
    for (int i = 0; i < 4; i++) begin
      step;
      check("post_rst_done", done[0], 1'b0);
      check("post_rst_busy", busy[0], 1'b0);
    end

    txn(0, LB_A, LB_B, LB_R, 4'h2, 1'b0, 1'b0);
    txn(1, LB_A, LB_B, LB_R, 4'h3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
